multi_edge_detect: RTL
======================

Name: multi_edge_detect

Overview:
- Parametrised, multi-channel successor to the single-bit edge detectors.
- Each channel does the following, in order:
  - synchronises an asynchronous level input;
  - removes glitches with a programmable stability filter;
  - runs a 4-state Moore FSM that emits a one-cycle tick on a rising edge, a falling edge or both, as selected per channel.
- Sits between raw pins/buttons and control logic; replaces per-signal instantiation of the single-bit detectors.

Parameters:
- CH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILT_W, 4, width of filter length and per-channel stability counter.

Ports:
- clk  input  1  system clock, all flops rising-edge.
- reset  input  1  asynchronous, active-low reset.
- level  input  CH  raw asynchronous levels, one bit per channel.
- mode  input  2*CH  per-channel edge select; bits [2i+1:2i] for channel i: 00 off, 01 rise, 10 fall, 11 both.
- filt_len  input  FILT_W  shared filter length L; 0 = no filtering.
- tick  output  CH  one-cycle edge pulse per channel.
- level_q  output  CH  filtered, synchronised level per channel.
- edge_any  output  1  OR of all tick bits.

Behaviour:
- Reset (reset=0, asynchronous), per channel:
  - synchroniser flops = 0, stable = 0, counter = 0, state = LOW;
  - tick = 0, level_q = 0, edge_any = 0.
- Synchroniser: level[i] shifts through SYNC_STAGES flops; sync_i = last flop.
- Filter, per channel, every clock:
  - if sync == stable: cnt <= 0;
  - else if cnt >= filt_len: stable <= sync, cnt <= 0;
  - else: cnt <= cnt+1.
  - stable therefore changes after sync has differed for L+1 consecutive cycles; a shorter pulse is discarded.
  - cnt never exceeds filt_len, so there is no overflow.
  - The compare is >=, so lowering filt_len mid-count takes effect next cycle.
  - level_q = stable.
- FSM per channel, states LOW, RISE, HIGH, FALL; transitions evaluated on stable:
  - LOW: stable=1 -> RISE, else LOW.
  - RISE: stable=1 -> HIGH, else FALL.
  - HIGH: stable=0 -> FALL, else HIGH.
  - FALL: stable=1 -> RISE, else LOW.
  - Back-to-back opposite edges (possible only with L=0) produce one tick each, on consecutive cycles.
- Output, Moore, decoded from the state register only:
  - tick[i] = (state==RISE && mode[2i]) || (state==FALL && mode[2i+1]).
  - mode is sampled in the RISE/FALL cycle: changing mode masks or unmasks only edges not yet ticked; no queued events.
  - mode=00 gives no ticks, but the FSM and level_q keep tracking.
- Latency: level change captured at clock edge k -> tick high for exactly one cycle, starting after edge k+SYNC_STAGES+L+1.
  - Default (SYNC_STAGES=2, L=0): 3 cycles.
- Reset release with level held high: the channel starts from LOW and produces one rise tick at normal latency.
- Reset asserted mid-filter or mid-tick: everything clears immediately; a pending tick is lost.
- Channels are fully independent; simultaneous edges on several channels each tick; edge_any = 1 if any tick bit is 1.

Optional Feature:
- Macro: MULTI_EDGE_MEALY_EN.
- Defined:
  - adds output port tick_early [CH], a Mealy-style combinational pulse;
  - tick_early[i] = ((state==LOW || state==FALL) && stable && mode[2i]) || ((state==HIGH || state==RISE) && !stable && mode[2i+1]);
  - asserts one cycle before the corresponding tick;
  - registered tick and edge_any are unchanged.
- Undefined: port and logic absent; Moore outputs only.

Decomposition:
- Package multi_edge_pkg holds:
  - 2-bit state encoding: LOW=00, RISE=01, HIGH=10, FALL=11;
  - mode constants: MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH.
- Sub-module edge_chan: one channel's synchroniser, filter counter and FSM.
- multi_edge_detect instantiates CH copies in a generate loop, slices mode, and ORs tick into edge_any.

Test Plan:
- Reset, then all levels 0, mode=all 11, L=0 -> tick, level_q, edge_any stay 0 for 20 cycles.
- Ch0 mode=01, L=0, level[0] 0->1 at edge k -> tick[0]=1 for exactly one cycle after edge k+3, level_q[0]=1; 1->0 later -> no tick.
- Ch1 mode=11, L=3:
  - 3-cycle high glitch -> no tick, level_q unchanged;
  - 10-cycle high pulse -> rise tick at k+6, fall tick 6 cycles after the falling capture.
- All 4 channels toggle on the same edge, mode=01 -> tick=4'b1111 for one cycle, edge_any=1 in that same cycle.
- level[2] held 1 through reset deassertion, mode=01 -> exactly one tick[2] 3 cycles after release.
- With MULTI_EDGE_MEALY_EN: L=0, mode=11, level[3] toggles -> tick_early[3] rises exactly one cycle before tick[3] for both edges.

Source files
------------

// File: rtl/multi_edge_pkg.sv
// Shared types and constants for the multi-channel edge detector.
// Optional feature macro used elsewhere: MULTI_EDGE_MEALY_EN.
package multi_edge_pkg;

    // Per-channel edge FSM encoding.
    typedef enum logic [1:0] {
        LOW  = 2'b00,
        RISE = 2'b01,
        HIGH = 2'b10,
        FALL = 2'b11
    } state_t;

    // Per-channel mode field: bit 0 enables rise ticks, bit 1 enables fall ticks.
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic logic rise_en(input logic [1:0] m);
        return (m == MODE_RISE) || (m == MODE_BOTH);
    endfunction

    function automatic logic fall_en(input logic [1:0] m);
        return (m == MODE_FALL) || (m == MODE_BOTH);
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, stability filter, 4-state Moore edge FSM.
// With MULTI_EDGE_MEALY_EN defined, also drives a combinational early tick.
module edge_chan
    import multi_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              level,
    input  logic [1:0]        mode,
    input  logic [FILT_W-1:0] filt_len,
    output logic              tick,
`ifdef MULTI_EDGE_MEALY_EN
    output logic              tick_early,
`endif
    output logic              level_q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   stable;
    logic [FILT_W-1:0]      cnt;
    state_t                 state, state_nxt;

    assign sync = sync_q[SYNC_STAGES-1];

    // Shift the raw level through the synchroniser chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], level};
    end

    // Accept a new level only after it has differed for filt_len+1 cycles;
    // >= lets a lowered filt_len take effect on a count already in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync == stable) begin
            cnt    <= '0;
        end else if (cnt >= filt_len) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOW;
        else        state <= state_nxt;
    end

    // Next state from the filtered level; RISE/FALL last exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            LOW:  state_nxt = stable ? RISE : LOW;
            RISE: state_nxt = stable ? HIGH : FALL;
            HIGH: state_nxt = stable ? HIGH : FALL;
            FALL: state_nxt = stable ? RISE : LOW;
            default: state_nxt = LOW;
        endcase
    end

    assign tick    = ((state == RISE) && rise_en(mode)) ||
                     ((state == FALL) && fall_en(mode));
    assign level_q = stable;

`ifdef MULTI_EDGE_MEALY_EN
    // Early tick: fires in the cycle the FSM is about to enter RISE/FALL.
    assign tick_early = (((state == LOW)  || (state == FALL)) &&  stable && rise_en(mode)) ||
                        (((state == HIGH) || (state == RISE)) && !stable && fall_en(mode));
`endif

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: CH independent edge_chan instances.
// Optional MULTI_EDGE_MEALY_EN adds the tick_early output port.
module multi_edge_detect
    import multi_edge_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH-1:0]     level,
    input  logic [2*CH-1:0]   mode,
    input  logic [FILT_W-1:0] filt_len,
    output logic [CH-1:0]     tick,
    output logic [CH-1:0]     level_q,
    output logic              edge_any
`ifdef MULTI_EDGE_MEALY_EN
    ,
    output logic [CH-1:0]     tick_early
`endif
);

    for (genvar i = 0; i < CH; i++) begin : gen_ch
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .level      (level[i]),
            .mode       (mode[2*i +: 2]),
            .filt_len   (filt_len),
            .tick       (tick[i]),
`ifdef MULTI_EDGE_MEALY_EN
            .tick_early (tick_early[i]),
`endif
            .level_q    (level_q[i])
        );
    end

    assign edge_any = |tick;

endmodule
